// File: rtl/saw_gen_if.sv
// FTW load channel for the sawtooth oscillator.
// Valid/ready handshake carrying the tuning word and glide request.
interface saw_gen_if #(
  parameter int ACC_W = 32
);
  logic [ACC_W-1:0] FTW_DATA;
  logic             FTW_VALID;
  logic             FTW_READY;
  logic             GLIDE_EN;

  modport master (
    output FTW_DATA,
    output FTW_VALID,
    output GLIDE_EN,
    input  FTW_READY
  );

  modport slave (
    input  FTW_DATA,
    input  FTW_VALID,
    input  GLIDE_EN,
    output FTW_READY
  );
endinterface

// File: rtl/saw_gen.sv
// Phase-accumulator sawtooth oscillator with exponential glide.
// Phase advances on SAMPLE_EN; SYNC zeroes phase; LOCKED low halts.
module saw_gen #(
  parameter int ACC_W       = 32,
  parameter int OUT_W       = 16,
  parameter int GLIDE_SHIFT = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             LOCKED,
  input  logic             SAMPLE_EN,
  input  logic             SYNC,
  saw_gen_if.slave         ftw,
  output logic [OUT_W-1:0] SAW,
  output logic             WRAP,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    HALT,
    RUN,
    SLEW
  } state_t;

  localparam logic [ACC_W:0] LIM =
    (ACC_W+1)'(1) << GLIDE_SHIFT;

  state_t            state;
  state_t            nstate;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  inc;
  logic [ACC_W-1:0]  tgt;
  logic [ACC_W-1:0]  inc_nx;
  logic [ACC_W-1:0]  tgt_nx;
  logic [ACC_W:0]    sum;
  logic [ACC_W:0]    d;
  logic [ACC_W:0]    mag;
  logic signed [ACC_W:0] dsh;
  logic              snap;
  logic              acpt;
  logic              adv;

  // Next state, increment and glide target.
  always_comb begin
    sum    = {1'b0, acc} + {1'b0, inc};
    d      = {1'b0, tgt} - {1'b0, inc};
    mag    = d[ACC_W] ? (~d + 1'b1) : d;
    dsh    = $signed(d) >>> GLIDE_SHIFT;
    snap   = mag < LIM;
    acpt   = ftw.FTW_VALID & ftw.FTW_READY;
    adv    = LOCKED & SAMPLE_EN & (state != HALT);
    nstate = state;
    inc_nx = inc;
    tgt_nx = tgt;
    if (acpt) begin
      tgt_nx = ftw.FTW_DATA;
      if (!ftw.GLIDE_EN) inc_nx = ftw.FTW_DATA;
    end
    if (!LOCKED) begin
      nstate = HALT;
    end else begin
      unique case (state)
        HALT: nstate = (inc != tgt) ? SLEW : RUN;
        RUN: begin
          if (acpt && ftw.GLIDE_EN &&
              ftw.FTW_DATA != inc)
            nstate = SLEW;
        end
        SLEW: begin
          if (SAMPLE_EN) begin
            if (snap) begin
              inc_nx = tgt;
              nstate = RUN;
            end else begin
              inc_nx = inc + dsh[ACC_W-1:0];
            end
          end
        end
        default: nstate = HALT;
      endcase
    end
  end

  // Registered state, phase and outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= HALT;
      acc           <= '0;
      inc           <= '0;
      tgt           <= '0;
      SAW           <= '0;
      WRAP          <= 1'b0;
      BUSY          <= 1'b0;
      ftw.FTW_READY <= 1'b0;
    end else begin
      state         <= nstate;
      inc           <= inc_nx;
      tgt           <= tgt_nx;
      ftw.FTW_READY <= (nstate == RUN);
      BUSY          <= (nstate == SLEW);
      WRAP          <= 1'b0;
      if (LOCKED && SYNC) begin
        acc <= '0;
        SAW <= '0;
      end else if (adv) begin
        acc  <= sum[ACC_W-1:0];
        SAW  <= sum[ACC_W-1 -: OUT_W];
        WRAP <= sum[ACC_W];
      end
    end
  end

endmodule
